stall_count_ctrl: RTL
=====================

Name: stall_count_ctrl

Overview:
Parametrised multi-cycle stall/latency counter for the MIPS CPU test datapath. It replaces the fixed 2-bit go/change counter with a programmable latency and three completion modes: hold, pulse and auto-reload. It also exposes busy and remaining-count status. Pipeline control uses it to stall issue while a multi-cycle unit (mul/div, memory) completes, then to release on change.

Parameters:
WIDTH, 4, bit width of latency input and internal counter; max latency 2^WIDTH-1
RST_LAT, 1, counter value loaded by reset; also the value used when lat is sampled as 0

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
go  input  1  request; must stay high for the whole operation; low aborts or acknowledges
lat  input  WIDTH  latency in cycles from first go edge to change; sampled only at start and reload
mode  input  2  completion mode, sampled at start: 0 HOLD, 1 PULSE, 2 RELOAD, 3 treated as HOLD
change  output  1  operation complete
busy  output  1  stall request: high while counting, before change
remaining  output  WIDTH  current counter value

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. All state updates occur on the rising edge of clk; rst has priority over everything.
- Reset values: state IDLE, count = RST_LAT, mode_q = HOLD. Outputs are then change=0, busy=0, remaining=RST_LAT.
- Effective latency: L = (lat==0) ? 1 : lat. A latency of 0 is clamped to 1; the minimum latency is therefore 1 cycle.
- States:
  - IDLE: count <= L every cycle (tracks lat). On go=1: count <= L-1, mode_q <= mode, go to COUNT.
  - COUNT, go=0: abort. Go to IDLE with count <= L. This takes priority over every other COUNT rule.
  - COUNT, go=1, count!=0: count <= count-1.
  - COUNT, go=1, count==0, mode_q HOLD: stay; change stays high until go drops.
  - COUNT, go=1, count==0, mode_q PULSE: go to DONE.
  - COUNT, go=1, count==0, mode_q RELOAD: count <= L-1 (lat resampled); stay in COUNT.
  - DONE: change=0 and busy=0. On go=0 go to IDLE (count <= L); otherwise stay.
- Outputs (decoded from registers only, no input-to-output combinational path):
  - change = (state==COUNT) && (count==0)
  - busy = (state==COUNT) && (count!=0)
  - remaining = count
- Latency: if go is first sampled high at edge k, change is high in the cycle after edge k+L-1, i.e. L cycles after go rises. With L=1 this matches the legacy 2-bit counter exactly.
- RELOAD with L=1: change is high continuously while go is held. With L>1: a one-cycle change pulse every L cycles.
- lat and mode changes mid-operation are ignored until the next start or reload.
- Counter never wraps: decrement occurs only when count!=0.
- Reset mid-operation: IDLE on the next edge; change and busy are low from that cycle.
- go low in the same cycle that change is high: change is still seen that cycle, and the block is in IDLE next cycle.

Decomposition:
- Shared package `stall_pkg`:
  - state enum: IDLE=2'd0, COUNT=2'd1, DONE=2'd2
  - mode constants: MODE_HOLD=2'd0, MODE_PULSE=2'd1, MODE_RELOAD=2'd2
- Single module. A separate sub-module is not natural: the counter and FSM share the load/decrement decision.

Test Plan:
- Reset with WIDTH=4, RST_LAT=1: hold rst 2 cycles, go=0 -> change=0, busy=0, remaining=1; rst with go=1 -> still IDLE outputs.
- Legacy equivalence: lat=1, mode=0, go held 5 cycles -> change high from the cycle after the first go edge and stays high; go low -> change=0 next cycle.
- lat=5, mode=1 (PULSE), go held 10 cycles:
  - busy high for 4 cycles with remaining 4,3,2,1
  - change high exactly one cycle, at remaining=0
  - then change=0 and busy=0 until go drops
  - go low then high again -> new 5-cycle sequence
- lat=3, mode=2 (RELOAD), go held 12 cycles -> change pulses on cycles 3, 6, 9 and 12 after go; changing lat to 2 mid-run takes effect only after the next pulse.
- Abort and clamp:
  - lat=7, go dropped after 3 cycles -> IDLE; remaining = lat next cycle; change never asserted.
  - lat=0 -> behaves as lat=1.
  - lat=15 -> change after exactly 15 cycles, no wrap.
- Reset mid-count: lat=8, assert rst at remaining=4 -> next cycle remaining=RST_LAT, busy=0, change=0.

Source files
------------

// File: rtl/stall_pkg.sv
// Shared types and constants for the stall/latency counter.
// FSM state encoding and completion-mode codes.
package stall_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] MODE_HOLD   = 2'd0;
  localparam logic [1:0] MODE_PULSE  = 2'd1;
  localparam logic [1:0] MODE_RELOAD = 2'd2;

endpackage

// File: rtl/stall_count_ctrl.sv
// Programmable multi-cycle stall counter with hold, pulse and auto-reload completion.
// Raises busy while counting and change when the programmed latency has elapsed.
module stall_count_ctrl
  import stall_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] lat,
  input  logic [1:0]       mode,
  output logic             change,
  output logic             busy,
  output logic [WIDTH-1:0] remaining
);

  localparam logic [WIDTH-1:0] RstCount = WIDTH'(RST_LAT);
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] lat_eff;

  // Zero latency is clamped so the minimum stall is one cycle.
  assign lat_eff = (lat == '0) ? One : lat;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        count_d = lat_eff;
        if (go) begin
          count_d = lat_eff - One;
          mode_d  = mode;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // Dropping go aborts or acknowledges, ahead of every other rule.
        if (!go) begin
          state_d = IDLE;
          count_d = lat_eff;
        end else if (count_q != '0) begin
          count_d = count_q - One;
        end else begin
          case (mode_q)
            MODE_PULSE:  state_d = DONE;
            MODE_RELOAD: count_d = lat_eff - One;
            default:     state_d = COUNT;
          endcase
        end
      end
      DONE: begin
        if (!go) begin
          state_d = IDLE;
          count_d = lat_eff;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = lat_eff;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= RstCount;
      mode_q  <= MODE_HOLD;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  assign change    = (state_q == COUNT) && (count_q == '0);
  assign busy      = (state_q == COUNT) && (count_q != '0);
  assign remaining = count_q;

endmodule
